// File: rtl/fetch_sprime_if.sv
// Bus bundle between fetch_sprime, the shared SRAM controller mux, DPRAM port A
// and the top-level decoder FSM.
interface fetch_sprime_if;
    logic        FS_start;
    logic        FS_done;
    logic        FS_last_block;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [15:0] SRAM_read_data;
    logic [6:0]  DP_address;
    logic [31:0] DP_write_data;
    logic        DP_we;

    // master: the fetch block itself
    modport master (
        input  FS_start,
        input  SRAM_read_data,
        output FS_done,
        output FS_last_block,
        output SRAM_address,
        output SRAM_we_n,
        output DP_address,
        output DP_write_data,
        output DP_we
    );

    // slave: decoder FSM / SRAM / DPRAM side
    modport slave (
        output FS_start,
        output SRAM_read_data,
        input  FS_done,
        input  FS_last_block,
        input  SRAM_address,
        input  SRAM_we_n,
        input  DP_address,
        input  DP_write_data,
        input  DP_we
    );
endinterface

// File: rtl/fetch_sprime.sv
// Fetches one 8x8 S' block per FS_start from SRAM into DPRAM port A, walking
// Y, U, V blocks in the same order the post-IDCT writer uses.
//
// state      | meaning
// -----------+------------------------------------------------------
// S_FS_IDLE  | waiting for FS_start
// S_FS_READ  | issuing SRAM addresses for elements k = 0..63
// S_FS_LO_1  | draining first in-flight read
// S_FS_LO_2  | draining second in-flight read
// S_FS_DONE  | FS_done pulse; block pointer advances on exit
module fetch_sprime #(
    parameter int unsigned RB_LAST = 29
) (
    input  logic           CLOCK_50_I,
    input  logic           Resetn,
    fetch_sprime_if.master fs
);

    localparam logic [17:0] Y_BASE = 18'd76800;
    localparam logic [17:0] U_BASE = 18'd153600;
    localparam logic [17:0] V_BASE = 18'd192000;
    localparam logic [4:0]  RB_END = RB_LAST[4:0];

    typedef enum logic [2:0] {
        S_FS_IDLE,
        S_FS_READ,
        S_FS_LO_1,
        S_FS_LO_2,
        S_FS_DONE
    } fs_state_t;

    typedef enum logic [1:0] {
        SEG_Y,
        SEG_U,
        SEG_V
    } seg_t;

    fs_state_t   state_q, state_d;
    logic [5:0]  k_q, k_d;
    logic [17:0] addr_q, addr_d;
    seg_t        seg_q, seg_d;
    logic [5:0]  cb_q, cb_d;
    logic [4:0]  rb_q, rb_d;
    logic        last_q, last_d;

    logic        rd_vld_q;
    logic [5:0]  rd_k_q;
    logic        dp_we_q;
    logic [6:0]  dp_addr_q;
    logic [31:0] dp_data_q;

    logic        fs_done;
    logic        adv;
    logic [5:0]  k_issue;
    logic [5:0]  cb_last;
    logic [7:0]  row;
    logic [17:0] row18;
    logic [17:0] row_off;
    logic [17:0] col_off;
    logic [17:0] base;
    logic [17:0] elem_addr;

    // Index of the element whose address is loaded at the coming edge.
    always_comb begin
        k_issue = 6'd0;
        if (state_q == S_FS_READ) begin
            k_issue = k_q + 6'd1;
        end
    end

    always_comb begin
        row     = {rb_q, 3'b000} + {5'd0, k_issue[5:3]};
        row18   = {10'd0, row};
        col_off = {9'd0, cb_q, k_issue[2:0]};
        base    = Y_BASE;
        row_off = (row18 << 8) + (row18 << 6);
        case (seg_q)
            SEG_U: begin
                base    = U_BASE;
                row_off = (row18 << 7) + (row18 << 5);
            end
            SEG_V: begin
                base    = V_BASE;
                row_off = (row18 << 7) + (row18 << 5);
            end
            default: begin
                base    = Y_BASE;
                row_off = (row18 << 8) + (row18 << 6);
            end
        endcase
        elem_addr = base + row_off + col_off;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        addr_d  = addr_q;
        adv     = 1'b0;
        fs_done = 1'b0;
        case (state_q)
            S_FS_IDLE: begin
                if (fs.FS_start) begin
                    state_d = S_FS_READ;
                    k_d     = 6'd0;
                    addr_d  = elem_addr;
                end
            end
            S_FS_READ: begin
                if (k_q == 6'd63) begin
                    state_d = S_FS_LO_1;
                end else begin
                    k_d    = k_issue;
                    addr_d = elem_addr;
                end
            end
            S_FS_LO_1: state_d = S_FS_LO_2;
            S_FS_LO_2: state_d = S_FS_DONE;
            S_FS_DONE: begin
                state_d = S_FS_IDLE;
                fs_done = 1'b1;
                adv     = 1'b1;
            end
            default: state_d = S_FS_IDLE;
        endcase
    end

    // Block pointer: CB fastest, then RB, then segment Y->U->V->Y.
    always_comb begin
        cb_last = (seg_q == SEG_Y) ? 6'd39 : 6'd19;
        seg_d   = seg_q;
        cb_d    = cb_q;
        rb_d    = rb_q;
        last_d  = last_q;
        if (adv) begin
            if (cb_q != cb_last) begin
                cb_d = cb_q + 6'd1;
            end else begin
                cb_d = 6'd0;
                if (rb_q != RB_END) begin
                    rb_d = rb_q + 5'd1;
                end else begin
                    rb_d = 5'd0;
                    case (seg_q)
                        SEG_Y:   seg_d = SEG_U;
                        SEG_U:   seg_d = SEG_V;
                        default: seg_d = SEG_Y;
                    endcase
                end
            end
            last_d = (seg_d == SEG_V) && (cb_d == 6'd19) && (rb_d == RB_END);
        end
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_FS_IDLE;
            k_q     <= 6'd0;
            addr_q  <= 18'd0;
            seg_q   <= SEG_Y;
            cb_q    <= 6'd0;
            rb_q    <= 5'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            addr_q  <= addr_d;
            seg_q   <= seg_d;
            cb_q    <= cb_d;
            rb_q    <= rb_d;
            last_q  <= last_d;
        end
    end

    // Read data for the address issued in cycle n is captured at the end of n+1.
    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            rd_vld_q  <= 1'b0;
            rd_k_q    <= 6'd0;
            dp_we_q   <= 1'b0;
            dp_addr_q <= 7'd0;
            dp_data_q <= 32'd0;
        end else begin
            rd_vld_q <= (state_q == S_FS_READ);
            rd_k_q   <= k_q;
            dp_we_q  <= rd_vld_q;
            if (rd_vld_q) begin
                dp_addr_q <= {1'b0, rd_k_q};
                dp_data_q <= {{16{fs.SRAM_read_data[15]}}, fs.SRAM_read_data};
            end
        end
    end

    assign fs.FS_done       = fs_done;
    assign fs.FS_last_block = last_q;
    assign fs.SRAM_address  = addr_q;
    assign fs.SRAM_we_n     = 1'b1;
    assign fs.DP_address    = dp_addr_q;
    assign fs.DP_write_data = dp_data_q;
    assign fs.DP_we         = dp_we_q;

endmodule
